// File: rtl/text_frame_display.sv
// text_frame_display: 40x30 character buffer scanned out in 640x480@60 VGA
// timing. Each cell is a 6-bit code looked up in an external font ROM as
// 16x16 pixel glyph rows. Rows of the latest print pass can be tinted.
module text_frame_display #(
   parameter int          COLS = 40,
   parameter int          ROWS = 30,
   parameter logic [23:0] FG   = 24'hFFFFFF,
   parameter logic [23:0] HL   = 24'h00FF00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_en,
   input  logic [5:0]  frame_char,
   input  logic [5:0]  frame_x,
   input  logic [5:0]  frame_y,
   input  logic        frame_we,
   input  logic [5:0]  line_start,
   input  logic [5:0]  line_end,
   input  logic        print_done,
   input  logic        clear,
   output logic        clear_busy,
   output logic [5:0]  glyph_char,
   output logic [3:0]  glyph_row,
   input  logic [15:0] glyph_bits,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n
);

   localparam int            DEPTH    = COLS * ROWS;
   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
   localparam logic [5:0]    COLS_W   = 6'(COLS);
   localparam logic [5:0]    ROWS_W   = 6'(ROWS);
   localparam logic [9:0]    H_VIS    = 10'd640;
   localparam logic [9:0]    H_SYNC_S = 10'd656;
   localparam logic [9:0]    H_SYNC_E = 10'd751;
   localparam logic [9:0]    H_LAST   = 10'd799;
   localparam logic [9:0]    V_VIS    = 10'd480;
   localparam logic [9:0]    V_SYNC_S = 10'd490;
   localparam logic [9:0]    V_SYNC_E = 10'd491;
   localparam logic [9:0]    V_LAST   = 10'd524;

   // Row-major cell address; the constant multiply reduces to shift-and-add.
   function automatic logic [AW-1:0] cell_addr(input logic [5:0] x, input logic [5:0] y);
      return (AW'(y) * AW'(COLS)) + AW'(x);
   endfunction

   // Highlight window over text rows; start > end means the pass wrapped.
   function automatic logic row_hl(input logic [4:0] r, input logic [5:0] s,
                                   input logic [5:0] e, input logic en);
      logic [5:0] rr;
      rr = {1'b0, r};
      if (!en)
         return 1'b0;
      if (s <= e)
         return (rr >= s) && (rr <= e);
      return (rr >= s) || (rr <= e);
   endfunction

   // Foreground colour for a lit visible pixel, black otherwise.
   function automatic logic [23:0] pix_colour(input logic pix, input logic vis, input logic hl);
      if (pix && vis)
         return hl ? HL : FG;
      return 24'h000000;
   endfunction

   // ---------------- clear sweep and shared write port ----------------
   logic          clear_busy_q, clear_busy_d;
   logic [AW-1:0] clr_addr_q, clr_addr_d;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [5:0]    wr_data;
   logic [5:0]    mem_q [DEPTH];

   // Next state of the clear sweep: restart on clear/reset, stop after the last cell.
   always_comb begin
      clear_busy_d = clear_busy_q;
      clr_addr_d   = clr_addr_q;
      if (reset || clear) begin
         clear_busy_d = 1'b1;
         clr_addr_d   = '0;
      end else if (clear_busy_q) begin
         clr_addr_d = clr_addr_q + 1'b1;
         if (clr_addr_q == LAST)
            clear_busy_d = 1'b0;
      end
   end

   // Clear sweep state registers.
   always_ff @(posedge clk) begin
      clear_busy_q <= clear_busy_d;
      clr_addr_q   <= clr_addr_d;
   end

   assign clear_busy = clear_busy_q;

   // Write port arbitration: sweep owns the port; printer writes need a legal cell.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      if (!reset && !clear) begin
         if (clear_busy_q) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr_q;
         end else if (frame_we && (frame_x < COLS_W) && (frame_y < ROWS_W)) begin
            wr_en   = 1'b1;
            wr_addr = cell_addr(frame_x, frame_y);
            wr_data = frame_char;
         end
      end
   end

   // Character RAM write side.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem_q[wr_addr] <= wr_data;
   end

   // ---------------- scan counters ----------------
   logic [9:0] hc_q, hc_d, vc_q, vc_d;
   logic       vis_now;
   logic [AW-1:0] rd_addr;

   // Next raster position, advancing once per pixel tick.
   always_comb begin
      hc_d = hc_q;
      vc_d = vc_q;
      if (pix_en) begin
         if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
         end else begin
            hc_d = hc_q + 10'd1;
         end
      end
   end

   // Raster counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         hc_q <= '0;
         vc_q <= '0;
      end else begin
         hc_q <= hc_d;
         vc_q <= vc_d;
      end
   end

   assign vis_now = (hc_q < H_VIS) && (vc_q < V_VIS);
   // Off-screen positions index past the buffer, so park the read at cell 0.
   assign rd_addr = vis_now ? cell_addr(hc_q[9:4], {1'b0, vc_q[8:4]}) : '0;

   // ---------------- stage 1: RAM read ----------------
   logic [5:0] rd_char_p1;
   logic       vld_p1, hs_p1, vs_p1;
   logic [3:0] row_p1, hcl_p1;
   logic [4:0] trow_p1;

   // Character read, old data on a same-cycle write.
   always_ff @(posedge clk) begin
      if (pix_en) begin
         rd_char_p1 <= mem_q[rd_addr];
         hcl_p1     <= hc_q[3:0];
         trow_p1    <= vc_q[8:4];
      end
   end

   // Stage-1 control flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1 <= 1'b0;
         hs_p1  <= 1'b1;
         vs_p1  <= 1'b1;
         row_p1 <= '0;
      end else if (pix_en) begin
         vld_p1 <= vis_now;
         hs_p1  <= !((hc_q >= H_SYNC_S) && (hc_q <= H_SYNC_E));
         vs_p1  <= !((vc_q >= V_SYNC_S) && (vc_q <= V_SYNC_E));
         row_p1 <= vc_q[3:0];
      end
   end

   // ---------------- stage 2: font ROM address ----------------
   logic [5:0] glyph_char_q;
   logic [3:0] glyph_row_q;
   logic       vld_p2, hs_p2, vs_p2, hl_p2;
   logic [3:0] hcl_p2;

   // Glyph address registers and control flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         glyph_char_q <= '0;
         glyph_row_q  <= '0;
         vld_p2       <= 1'b0;
         hs_p2        <= 1'b1;
         vs_p2        <= 1'b1;
      end else if (pix_en) begin
         glyph_char_q <= vld_p1 ? rd_char_p1 : 6'd0;
         glyph_row_q  <= row_p1;
         vld_p2       <= vld_p1;
         hs_p2        <= hs_p1;
         vs_p2        <= vs_p1;
      end
   end

   // Highlight decision and pixel column carried alongside the ROM lookup.
   always_ff @(posedge clk) begin
      if (pix_en) begin
         hl_p2  <= row_hl(trow_p1, line_start, line_end, print_done);
         hcl_p2 <= hcl_p1;
      end
   end

   assign glyph_char = glyph_char_q;
   assign glyph_row  = glyph_row_q;

   // ---------------- stage 3: pixel output ----------------
   logic [23:0] rgb_q;
   logic        hs_q, vs_q, blank_n_q;

   // Select the glyph bit (MSB leftmost) and drive colour and syncs.
   always_ff @(posedge clk) begin
      if (reset) begin
         rgb_q     <= '0;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b0;
      end else if (pix_en) begin
         rgb_q     <= pix_colour(glyph_bits[4'd15 - hcl_p2], vld_p2, hl_p2);
         hs_q      <= hs_p2;
         vs_q      <= vs_p2;
         blank_n_q <= vld_p2;
      end
   end

   assign vga_r       = rgb_q[23:16];
   assign vga_g       = rgb_q[15:8];
   assign vga_b       = rgb_q[7:0];
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign vga_blank_n = blank_n_q;

endmodule

// File: doc/text_frame_display.md
# text_frame_display

Text-mode display stage downstream of the cycle printer. Holds a 40×30 grid of 6-bit character codes written through the printer's `frame_*` write port. Scans the grid in 640×480@60 VGA timing, fetches glyph rows from an external font ROM, and drives RGB/sync. Rows of the most recent print pass (`line_start`..`line_end`) are drawn in a highlight colour once `print_done` is high.

## Interface
Parameters:
- `COLS`, 40, text columns
- `ROWS`, 30, text rows
- `FG`, 24'hFFFFFF, normal foreground RGB
- `HL`, 24'h00FF00, highlight foreground RGB

Ports:
- `clk`  in  1  system clock; one clock domain
- `reset`  in  1  synchronous, active-high reset
- `pix_en`  in  1  pixel-rate enable, one `clk` pulse per pixel; never high on two consecutive cycles
- `frame_char`  in  6  character code to store; 0 = blank
- `frame_x`  in  6  column
- `frame_y`  in  6  row
- `frame_we`  in  1  write strobe, one write per `clk`
- `line_start`  in  6  first row of latest print pass
- `line_end`  in  6  last row of latest print pass
- `print_done`  in  1  highlight enable
- `clear`  in  1  start full-buffer clear; single-cycle pulse
- `clear_busy`  out  1  clear sweep in progress
- `glyph_char`  out  6  font ROM character address
- `glyph_row`  out  4  font ROM row address within the cell
- `glyph_bits`  in  16  font ROM row data; bit 15 = leftmost pixel; valid by the next `pix_en` after the address changes
- `vga_r`, `vga_g`, `vga_b`  out  8 each  pixel colour
- `vga_hs`, `vga_vs`  out  1  syncs, active low
- `vga_blank_n`  out  1  low outside the visible area

## Operation
- **Storage:** 1200 × 6-bit dual-port RAM.
  - Address = y*40 + x, computed as (y<<5)+(y<<3)+x, 11 bits.
  - Write port is shared by printer writes and the clear sweep.
  - Read port is used only by the scanner.
- **Printer writes:** accepted when `frame_we`=1, `frame_x`<40, `frame_y`<30 and `clear_busy`=0. Out-of-range writes and writes during a clear are dropped silently.
- **Clear:** a `clear` pulse, or `reset`, sets the clear address to 0 and `clear_busy` to 1.
  - Each following `clk` writes 0 to the clear address and increments it.
  - `clear_busy` falls on the cycle after address 1199 is written: 1200 cycles total.
  - A `clear` pulse during a sweep restarts it at 0.
- **Scanner counters:** `hc` 0..799 and `vc` 0..524, advancing on `pix_en`. `hc` wraps 799→0 and increments `vc`; `vc` wraps 524→0.
  - Visible: hc<640 and vc<480.
  - `vga_hs` low for hc 656..751.
  - `vga_vs` low for vc 490..491.
- **Read pipeline:** 3 stages, each advancing on `pix_en`.
  - S1: RAM read at column hc[9:4], row vc[8:4].
  - S2: register `glyph_char` = RAM data and `glyph_row` = vc[3:0]. Non-visible pixels force `glyph_char`=0.
  - S3: pixel = glyph_bits[15 − hc[3:0]], using the delayed hc.
  - Sync and visible flags are delayed to match.
- **Colour:**
  - Pixel set and visible → `HL` if the row is highlighted, else `FG`.
  - Otherwise → 0.
- **Highlight rule:** active only when `print_done`=1.
  - If `line_start` ≤ `line_end`: row r is highlighted when `line_start` ≤ r ≤ `line_end`.
  - Otherwise (wrapped pass): r ≥ `line_start` or r ≤ `line_end`.
  - Evaluated at S2 using `print_done`, `line_start` and `line_end` as sampled that cycle.

## Timing
- **Reset values:**
  - `hc`=`vc`=0
  - `vga_hs`=`vga_vs`=1, `vga_blank_n`=0
  - `vga_r`/`vga_g`/`vga_b`=0
  - `glyph_char`=0, `glyph_row`=0
  - `clear_busy`=1 from the first cycle after reset is asserted; clear sweep starts at the first cycle with reset low
  - Reset mid-frame or mid-clear restarts both the counters and the sweep.
- **Latency:** pixel for (hc,vc) appears on the outputs 3 `pix_en` ticks after the counters hold (hc,vc). Syncs and blank carry the same 3-tick delay.
- **Write-to-display:** a write is visible at the next scan of its cell, or the scan after if the RAM read of that cell and the write fall in the same `clk`. Read-during-write returns old data.
- **Simultaneous events:** `clear` and `frame_we` in the same cycle → the write is dropped and the sweep starts.
- **Without `pix_en`:** scanner and pipeline hold; writes and clear proceed regardless.

## Test plan
- **Reset/clear:** reset 3 cycles, release → `clear_busy`=1 for exactly 1200 cycles, then 0. Readback of all 1200 cells via scanner → every `glyph_char`=0.
- **Write and display:** write char 5 at (x=2,y=1), `print_done`=0, font ROM model returns 16'h8000 for char 5.
  - Pixel at hc=32, vc=16..31 → RGB = FFFFFF.
  - Pixel at hc=33 → 0.
  - Output appears 3 `pix_en` ticks after the counters reach 32.
- **Out-of-range and clear collisions:**
  - Write char 7 at (40,0) and at (0,30) → no cell changes.
  - `frame_we` during `clear_busy` → dropped.
  - `frame_we` together with `clear` → dropped; sweep starts at address 0.
- **Sync timing:**
  - `vga_hs` low for exactly 96 ticks starting at hc=656 (+3 latency).
  - `vga_vs` low for 2 lines at vc=490.
  - `vga_blank_n` low for hc≥640 or vc≥480.
  - Frame length 420000 ticks.
- **Highlight wrap:** `print_done`=1, `line_start`=28, `line_end`=1, char on rows 0, 5, 29.
  - Rows 0 and 29 → 00FF00.
  - Row 5 → FFFFFF.
  - `line_start`=3, `line_end`=6 → row 5 green, row 0 white.
- **Reset mid-frame:** assert reset at hc=300, vc=200 → next cycle all outputs at their reset values. After release, counters resume at 0,0 and the clear sweep runs 1200 cycles.
